// File: rtl/conv_stream_pkg.sv
// Shared types and sizing for the conv layer x-stream transmitter.
package conv_stream_pkg;
    localparam int T       = 16;
    localparam int X_COUNT = 64;
    localparam int ADDR_X  = $clog2(X_COUNT);

    typedef logic signed [T-1:0] word_t;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} tx_state_t;
endpackage

// File: rtl/conv_x_stream_tx_if.sv
// Host write port plus conv x-stream port of the ping-pong transmitter.
interface conv_x_stream_tx_if;
    import conv_stream_pkg::*;

    word_t      s_data_in;
    logic       s_valid;
    logic       s_ready;
    word_t      m_data_out_x;
    logic       m_valid_x;
    logic       m_ready_x;
    logic       vec_done;
    logic [1:0] banks_full;

    modport slave (
        input  s_data_in, s_valid, m_ready_x,
        output s_ready, m_data_out_x, m_valid_x, vec_done, banks_full
    );

    modport master (
        output s_data_in, s_valid, m_ready_x,
        input  s_ready, m_data_out_x, m_valid_x, vec_done, banks_full
    );
endinterface

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: write has priority, read data registered.
module sp_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)      mem[addr] <= wdata;
        else if (re) rdata     <= mem[addr];
    end
endmodule

// File: rtl/stream_skid_fifo.sv
// Two-entry fall-through output buffer; the head word stays put while the
// consumer stalls, and an empty buffer passes the RAM word straight out.
module stream_skid_fifo
    import conv_stream_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  word_t      in_data,
    output logic       out_valid,
    output word_t      out_data,
    input  logic       out_ready,
    output logic [1:0] count
);
    word_t mem [2];
    logic  wp, rp, bypass, push, pop;

    // The producer never presents a word while both entries are occupied.
    assign bypass    = (count == 2'd0) && out_ready;
    assign push      = in_valid && !bypass;
    assign pop       = out_ready && (count != 2'd0);
    assign out_valid = in_valid || (count != 2'd0);

    always_comb begin
        out_data = '0;
        if (count != 2'd0) out_data = mem[rp];
        else if (in_valid) out_data = in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            wp    <= 1'b0;
            rp    <= 1'b0;
        end else begin
            if (push) wp <= !wp;
            if (pop)  rp <= !rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_data;
    end
endmodule

// File: rtl/conv_x_stream_tx.sv
// Ping-pong vector transmitter: host fills one bank while the other bank
// streams word-by-word into the conv block's x port.
module conv_x_stream_tx
    import conv_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    conv_x_stream_tx_if.slave bus
);
    localparam logic [ADDR_X-1:0] LAST = ADDR_X'(X_COUNT - 1);

    tx_state_t         state, state_nxt;
    logic [ADDR_X-1:0] wr_ptr, rd_ptr, out_cnt;
    logic              wr_bank, rd_bank, rd_sel, rd_vld;
    logic [1:0]        full, full_nxt, banks_full_q, fifo_cnt;
    logic              wr_en, wr_last, hs, last_hs, space, iss_ok, issue, iss_bank;
    word_t             q [2];
    word_t             rd_data;

    assign bus.s_ready    = !full[wr_bank];
    assign bus.banks_full = banks_full_q;
    assign bus.vec_done   = last_hs;

    assign wr_en   = bus.s_valid && !full[wr_bank];
    assign wr_last = wr_en && (wr_ptr == LAST);
    assign hs      = bus.m_valid_x && bus.m_ready_x;
    assign last_hs = hs && (out_cnt == LAST);
    // Reads still in the RAM pipeline count against the buffer's two slots.
    assign space   = (3'(fifo_cnt) + 3'(rd_vld)) < 3'd2;
    assign rd_data = rd_sel ? q[1] : q[0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic bank_we;
        assign bank_we = wr_en && (wr_bank == 1'(b));
        sp_ram #(.W(T), .DEPTH(X_COUNT)) u_ram (
            .clk   (clk),
            .we    (bank_we),
            .re    (issue && (iss_bank == 1'(b))),
            .addr  (bank_we ? wr_ptr : rd_ptr),
            .wdata (bus.s_data_in),
            .rdata (q[b])
        );
    end

    stream_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_vld),
        .in_data   (rd_data),
        .out_valid (bus.m_valid_x),
        .out_data  (bus.m_data_out_x),
        .out_ready (bus.m_ready_x),
        .count     (fifo_cnt)
    );

    // DRAIN prefetches from the other bank so the bank switch costs no cycle.
    always_comb begin
        state_nxt = state;
        iss_bank  = rd_bank;
        iss_ok    = 1'b0;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                iss_ok = full[rd_bank];
                if (full[rd_bank]) state_nxt = STREAM;
            end
            STREAM: begin
                iss_ok = 1'b1;
                if (space && rd_ptr == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                iss_bank = !rd_bank;
                iss_ok   = full[!rd_bank];
                if (last_hs) state_nxt = full[!rd_bank] ? STREAM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        issue = iss_ok && space;
    end

    always_comb begin
        full_nxt = full;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
        if (last_hs) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            full         <= 2'b00;
            banks_full_q <= 2'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_cnt      <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            rd_sel       <= 1'b0;
            rd_vld       <= 1'b0;
        end else begin
            state        <= state_nxt;
            full         <= full_nxt;
            banks_full_q <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
            rd_vld       <= issue;
            if (wr_en) begin
                wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
                if (wr_last) wr_bank <= !wr_bank;
            end
            if (issue) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                rd_sel <= iss_bank;
            end
            if (hs) out_cnt <= last_hs ? '0 : out_cnt + 1'b1;
            if (last_hs) rd_bank <= !rd_bank;
        end
    end
endmodule
